// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - valid/ready request/response front-end for a single-port synchronous RAM
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_w_clk,
    input  logic                  i_w_rst,
    input  logic                  i_w_req_valid,
    output logic                  o_w_req_ready,
    input  logic                  i_w_req_we,
    input  logic [ADDR_WIDTH-1:0] i_w_req_addr,
    input  logic [DATA_WIDTH-1:0] i_w_req_wdata,
    output logic                  o_w_rsp_valid,
    input  logic                  i_w_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
    output logic                  o_w_mem_cs,
    output logic                  o_w_mem_we,
    output logic [ADDR_WIDTH-1:0] o_w_mem_addr,
    output logic [DATA_WIDTH-1:0] o_w_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_w_mem_rdata
);

    // pend_q: a read strobe was issued last cycle, so i_w_mem_rdata carries its data now
    logic                  pend_q, pend_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];

    logic [1:0] occupancy;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // Credit check: accept only when every in-flight read already has a buffer slot
    always_comb begin
        fifo_empty    = (cnt_q == 2'd0);
        occupancy     = cnt_q + {1'b0, pend_q};
        o_w_req_ready = !i_w_rst && (occupancy < 2'd2);
        o_w_mem_cs    = i_w_req_valid && o_w_req_ready;
        o_w_mem_we    = i_w_req_we;
        o_w_mem_addr  = i_w_req_addr;
        o_w_mem_wdata = i_w_req_wdata;
    end

    // Response side: FIFO head has priority, otherwise bypass the RAM output directly
    always_comb begin
        o_w_rsp_valid = !fifo_empty || pend_q;
        o_w_rsp_rdata = fifo_empty ? i_w_mem_rdata : fifo_q[rd_ptr_q];
        push          = pend_q && !(fifo_empty && i_w_rsp_ready);
        pop           = !fifo_empty && i_w_rsp_ready;
    end

    // Next-state for pipeline flag, count and pointers
    always_comb begin
        pend_d   = o_w_mem_cs && !i_w_req_we;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    // Control state; reset discards in-flight and buffered reads
    always_ff @(posedge i_w_clk or posedge i_w_rst) begin
        if (i_w_rst) begin
            pend_q   <= 1'b0;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Data storage needs no reset; validity is tracked by cnt_q
    always_ff @(posedge i_w_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= i_w_mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed self-checking bench for mem_req_ctrl with a RAM model
module tb_mem_req_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_cs;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] ram [256];

    int n_assert = 0;
    int n_fail   = 0;

    mem_req_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .i_w_clk       (clk),
        .i_w_rst       (rst),
        .i_w_req_valid (req_valid),
        .o_w_req_ready (req_ready),
        .i_w_req_we    (req_we),
        .i_w_req_addr  (req_addr),
        .i_w_req_wdata (req_wdata),
        .o_w_rsp_valid (rsp_valid),
        .i_w_rsp_ready (rsp_ready),
        .o_w_rsp_rdata (rsp_rdata),
        .o_w_mem_cs    (mem_cs),
        .o_w_mem_we    (mem_we),
        .o_w_mem_addr  (mem_addr),
        .o_w_mem_wdata (mem_wdata),
        .i_w_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model with registered read data
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Buffered plus in-flight reads must never exceed two
    always @(negedge clk) begin
        if (!rst) begin
            n_assert++;
            assert (({1'b0, dut.cnt_q} + {2'b0, dut.pend_q}) <= 3'd2)
            else begin
                n_fail++;
                $error("FAIL occupancy_bound observed=%0d expected<=2", dut.cnt_q + dut.pend_q);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;

        // 1: reset holds everything off, ready returns on release
        tick(); #1;
        chk("rst_cs",        {7'b0, mem_cs},    8'h00);
        chk("rst_req_ready", {7'b0, req_ready}, 8'h00);
        chk("rst_rsp_valid", {7'b0, rsp_valid}, 8'h00);
        tick();
        req_valid = 1'b0; rst = 1'b0; #1;
        chk("rel_req_ready", {7'b0, req_ready}, 8'h01);
        chk("rel_rsp_valid", {7'b0, rsp_valid}, 8'h00);

        // 2: write then read back with 1-cycle latency
        drv(1, 1, 8'h10, 8'hA5);
        chk("wr_cs",    {7'b0, mem_cs}, 8'h01);
        chk("wr_we",    {7'b0, mem_we}, 8'h01);
        chk("wr_addr",  mem_addr,       8'h10);
        chk("wr_wdata", mem_wdata,      8'hA5);
        tick();
        drv(1, 0, 8'h10, 8'h00);
        chk("rd_cs",        {7'b0, mem_cs},    8'h01);
        chk("rd_no_rsp",    {7'b0, rsp_valid}, 8'h00);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("rd_rsp_valid", {7'b0, rsp_valid}, 8'h01);
        chk("rd_rdata",     rsp_rdata,         8'hA5);
        chk("rd_req_ready", {7'b0, req_ready}, 8'h01);
        tick();
        chk("rd_consumed",  {7'b0, rsp_valid}, 8'h00);

        // 3: preload, then stream reads against backpressure
        for (int i = 1; i <= 3; i++) begin
            drv(1, 1, 8'(i), 8'(i));
            chk("pre_cs", {7'b0, mem_cs}, 8'h01);
            tick();
        end
        rsp_ready = 1'b0;
        drv(1, 0, 8'h01, 8'h00);
        chk("s_r1_cs", {7'b0, mem_cs}, 8'h01);
        tick();
        drv(1, 0, 8'h02, 8'h00);
        chk("s_r2_cs",    {7'b0, mem_cs}, 8'h01);
        chk("s_r2_rdata", rsp_rdata,      8'h01);
        tick();
        drv(1, 0, 8'h03, 8'h00);
        chk("s_full_ready", {7'b0, req_ready}, 8'h00);
        chk("s_full_cs",    {7'b0, mem_cs},    8'h00);
        tick();
        chk("s_hold_cs", {7'b0, mem_cs}, 8'h00);
        rsp_ready = 1'b1; #1;
        chk("s_hold_cs2",  {7'b0, mem_cs},    8'h00);
        chk("s_rsp1",      rsp_rdata,         8'h01);
        chk("s_rsp1_v",    {7'b0, rsp_valid}, 8'h01);
        tick();
        chk("s_r3_cs", {7'b0, mem_cs}, 8'h01);
        chk("s_rsp2",  rsp_rdata,      8'h02);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("s_rsp3_v", {7'b0, rsp_valid}, 8'h01);
        chk("s_rsp3",   rsp_rdata,         8'h03);
        tick();
        chk("s_drained", {7'b0, rsp_valid}, 8'h00);

        // 4: write stalls at occupancy 2 until a pop frees a slot
        rsp_ready = 1'b0;
        drv(1, 0, 8'h01, 8'h00);
        tick();
        drv(1, 0, 8'h02, 8'h00);
        tick();
        drv(1, 1, 8'h20, 8'h55);
        chk("w_stall_cs", {7'b0, mem_cs}, 8'h00);
        tick();
        chk("w_stall_cs2", {7'b0, mem_cs}, 8'h00);
        rsp_ready = 1'b1; #1;
        chk("w_stall_cs3", {7'b0, mem_cs}, 8'h00);
        chk("w_pop1",      rsp_rdata,      8'h01);
        tick();
        chk("w_go_cs", {7'b0, mem_cs}, 8'h01);
        chk("w_go_we", {7'b0, mem_we}, 8'h01);
        chk("w_pop2",  rsp_rdata,      8'h02);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("w_once_cs", {7'b0, mem_cs},    8'h00);
        chk("w_empty",   {7'b0, rsp_valid}, 8'h00);
        drv(1, 0, 8'h20, 8'h00);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("w_readback", rsp_rdata, 8'h55);
        tick();

        // 5: push+pop coincide, then accept a read in the same cycle as a pop
        rsp_ready = 1'b0;
        drv(1, 0, 8'h01, 8'h00);
        tick();
        drv(1, 0, 8'h02, 8'h00);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        rsp_ready = 1'b1; #1;
        chk("pp_head1", rsp_rdata, 8'h01);
        tick();
        drv(1, 0, 8'h03, 8'h00);
        chk("pp_cs",    {7'b0, mem_cs}, 8'h01);
        chk("pp_head2", rsp_rdata,      8'h02);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("pp_new_v", {7'b0, rsp_valid}, 8'h01);
        chk("pp_new",   rsp_rdata,         8'h03);
        tick();
        chk("pp_empty", {7'b0, rsp_valid}, 8'h00);

        // 6: reset with two buffered responses drops them, RAM stays intact
        rsp_ready = 1'b0;
        drv(1, 0, 8'h01, 8'h00);
        tick();
        drv(1, 0, 8'h02, 8'h00);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        tick();
        chk("r_full_v", {7'b0, rsp_valid}, 8'h01);
        #1; rst = 1'b1; #1;
        chk("r_mid_v",     {7'b0, rsp_valid}, 8'h00);
        chk("r_mid_ready", {7'b0, req_ready}, 8'h00);
        tick();
        rst = 1'b0; rsp_ready = 1'b1; #1;
        chk("r_rel_v",     {7'b0, rsp_valid}, 8'h00);
        chk("r_rel_ready", {7'b0, req_ready}, 8'h01);
        tick();
        chk("r_no_stale", {7'b0, rsp_valid}, 8'h00);
        drv(1, 0, 8'h03, 8'h00);
        tick();
        drv(1, 0, 8'h10, 8'h00);
        chk("r_ram3", rsp_rdata, 8'h03);
        tick();
        drv(0, 0, 8'h00, 8'h00);
        chk("r_ram10", rsp_rdata, 8'hA5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
